multicycle_ctrl: RTL and testbench

// - Multi-cycle control FSM for the RV32I subset core; the producer of alu_ctrl for the ALU and the consumer of its EQ flag.
// - Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction, drives datapath enables, and handshakes with instruction and data memory.
// - Supported: add sub and slt; addi andi slti; lw sw; beq bne; jal. Any other encoding traps.

---
 rtl/multicycle_ctrl_pkg.sv | 31 +++
 rtl/multicycle_ctrl_decode.sv | 77 +++++++
 rtl/multicycle_ctrl.sv | 149 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control path.
// Contents: ALU operation, immediate format, writeback source and FSM state
// enums; the instruction class enum produced by the decoder; and the opcode,
// funct3 and funct7 constants of the supported instruction subset.
package multicycle_ctrl_pkg;

    typedef enum logic [1:0] {SUM_OP, SUB_OP, AND_OP, SLT_OP} alu_ctrl_t;
    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;
    typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_src_t;
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEM, WB, TRAP} ctrl_state_t;
    typedef enum logic [2:0] {CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE,
                              CLS_BRANCH, CLS_JAL} instr_class_t;

    localparam logic [6:0] OPC_ALU_R  = 7'b0110011;
    localparam logic [6:0] OPC_ALU_I  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LSW = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction decoder for the multi-cycle controller.
// Ports:
//   instr    in  32  instruction register contents
//   iclass   out     instruction class (R-ALU, I-ALU, load, store, branch, jal)
//   alu_ctrl out     ALU operation used in EXECUTE
//   imm_src  out     immediate format
//   illegal  out  1  encoding outside the supported subset
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t iclass,
    output alu_ctrl_t    alu_ctrl,
    output imm_src_t     imm_src,
    output logic         illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        iclass   = CLS_ALU_R;
        alu_ctrl = SUM_OP;
        imm_src  = IMM_I;
        illegal  = 1'b0;
        case (opcode)
            OPC_ALU_R: begin
                iclass = CLS_ALU_R;
                case (funct3)
                    F3_ADD: begin
                        if (funct7 == F7_ALT)       alu_ctrl = SUB_OP;
                        else if (funct7 != F7_BASE) illegal  = 1'b1;
                    end
                    F3_AND:  begin alu_ctrl = AND_OP; illegal = (funct7 != F7_BASE); end
                    F3_SLT:  begin alu_ctrl = SLT_OP; illegal = (funct7 != F7_BASE); end
                    default: illegal = 1'b1;
                endcase
            end
            OPC_ALU_I: begin
                // funct7 bits belong to the immediate here, so they are not checked.
                iclass = CLS_ALU_I;
                case (funct3)
                    F3_ADD:  alu_ctrl = SUM_OP;
                    F3_AND:  alu_ctrl = AND_OP;
                    F3_SLT:  alu_ctrl = SLT_OP;
                    default: illegal  = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                iclass  = CLS_LOAD;
                illegal = (funct3 != F3_LSW);
            end
            OPC_STORE: begin
                iclass  = CLS_STORE;
                imm_src = IMM_S;
                illegal = (funct3 != F3_LSW);
            end
            OPC_BRANCH: begin
                iclass   = CLS_BRANCH;
                alu_ctrl = SUB_OP;
                imm_src  = IMM_B;
                illegal  = (funct3 != F3_BEQ) && (funct3 != F3_BNE);
            end
            OPC_JAL: begin
                iclass  = CLS_JAL;
                imm_src = IMM_J;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I subset core.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB, drives datapath enables and handshakes
// with instruction and data memory. A handshake watchdog (TIMEOUT_CYCLES != 0)
// and illegal encodings both send the FSM to a sticky TRAP state.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   instr, alu_eq         instruction register, ALU equality flag
//   imem_ready/dmem_ready memory handshake completions
//   imem_req, ir_en       fetch request, instruction register load
//   alu_ctrl, alu_src_b, imm_src, result_src, reg_write   datapath controls
//   dmem_req, dmem_we     data memory request / write
//   pc_en, pc_src         PC update strobe and select (0 = PC+4, 1 = PC+imm)
//   trap                  sticky illegal-instruction / timeout flag
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        alu_eq,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_en,
    output alu_ctrl_t   alu_ctrl,
    output logic        alu_src_b,
    output imm_src_t    imm_src,
    output result_src_t result_src,
    output logic        reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        pc_en,
    output logic        pc_src,
    output logic        trap
);

    localparam logic [CNT_WIDTH-1:0] WD_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    ctrl_state_t          state, state_next;
    logic [CNT_WIDTH-1:0] wd_cnt;
    logic                 waiting;
    logic                 wd_hit;

    instr_class_t dec_class;
    alu_ctrl_t    dec_alu;
    imm_src_t     dec_imm;
    logic         dec_illegal;

    multicycle_ctrl_decode u_decode (
        .instr    (instr),
        .iclass   (dec_class),
        .alu_ctrl (dec_alu),
        .imm_src  (dec_imm),
        .illegal  (dec_illegal)
    );

    assign waiting = ((state == FETCH) && !imem_ready) || ((state == MEM) && !dmem_ready);
    // Fires on the TIMEOUT_CYCLES-th consecutive waiting cycle.
    assign wd_hit  = (TIMEOUT_CYCLES != 0) && waiting && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wd_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) wd_cnt <= '0;
            else if (waiting)        wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        ir_en      = 1'b0;
        alu_ctrl   = SUM_OP;
        alu_src_b  = 1'b0;
        imm_src    = IMM_I;
        result_src = RES_ALU;
        reg_write  = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 1'b0;
        trap       = 1'b0;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_en      = 1'b1;
                    state_next = DECODE;
                end else if (wd_hit) begin
                    state_next = TRAP;
                end
            end
            DECODE: state_next = dec_illegal ? TRAP : EXECUTE;
            EXECUTE: begin
                alu_ctrl = dec_alu;
                imm_src  = dec_imm;
                case (dec_class)
                    CLS_ALU_R: state_next = WB;
                    CLS_ALU_I: begin alu_src_b = 1'b1; state_next = WB; end
                    CLS_LOAD, CLS_STORE: begin alu_src_b = 1'b1; state_next = MEM; end
                    CLS_BRANCH: begin
                        pc_en      = 1'b1;
                        pc_src     = (instr[14:12] == F3_BNE) ? !alu_eq : alu_eq;
                        state_next = FETCH;
                    end
                    CLS_JAL: begin
                        pc_en      = 1'b1;
                        pc_src     = 1'b1;
                        reg_write  = 1'b1;
                        result_src = RES_PC4;
                        state_next = FETCH;
                    end
                    default: state_next = TRAP;
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (dec_class == CLS_STORE);
                if (dmem_ready) begin
                    if (dec_class == CLS_STORE) begin
                        pc_en      = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = WB;
                    end
                end else if (wd_hit) begin
                    state_next = TRAP;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                pc_en      = 1'b1;
                result_src = (dec_class == CLS_LOAD) ? RES_MEM : RES_ALU;
                state_next = FETCH;
            end
            TRAP:    trap = 1'b1;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A per-instruction model expands each
// instruction into its expected per-cycle output sequence; a compare process
// checks two instances (watchdog off / watchdog = 4) on every cycle.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    typedef struct packed {
        logic       imem_req;
        logic       ir_en;
        logic [1:0] alu_ctrl;
        logic       alu_src_b;
        logic [1:0] imm_src;
        logic [1:0] result_src;
        logic       reg_write;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_en;
        logic       pc_src;
        logic       trap;
    } outs_t;

    typedef struct {
        outs_t       e;
        outs_t       ew;
        logic        ir;
        logic        dr;
        logic        eq;
        logic [31:0] ins;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        alu_eq, imem_ready, dmem_ready;

    logic        imem_req, ir_en, alu_src_b, reg_write, dmem_req, dmem_we, pc_en, pc_src, trap;
    alu_ctrl_t   alu_ctrl;
    imm_src_t    imm_src;
    result_src_t result_src;

    logic        w_imem_req, w_ir_en, w_alu_src_b, w_reg_write, w_dmem_req, w_dmem_we;
    logic        w_pc_en, w_pc_src, w_trap;
    alu_ctrl_t   w_alu_ctrl;
    imm_src_t    w_imm_src;
    result_src_t w_result_src;

    outs_t act, act_wd, cur, cur_wd;
    logic  cur_valid;
    int    vectors;
    int    miscompares;
    vec_t  q[$];

    multicycle_ctrl #(.TIMEOUT_CYCLES(0), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .alu_eq(alu_eq),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_en(ir_en), .alu_ctrl(alu_ctrl), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .result_src(result_src), .reg_write(reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .pc_en(pc_en), .pc_src(pc_src), .trap(trap)
    );

    multicycle_ctrl #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut_wd (
        .clk(clk), .rst_n(rst_n), .instr(instr), .alu_eq(alu_eq),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(w_imem_req), .ir_en(w_ir_en), .alu_ctrl(w_alu_ctrl), .alu_src_b(w_alu_src_b),
        .imm_src(w_imm_src), .result_src(w_result_src), .reg_write(w_reg_write),
        .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .pc_en(w_pc_en), .pc_src(w_pc_src),
        .trap(w_trap)
    );

    always_comb begin
        act    = {imem_req, ir_en, alu_ctrl, alu_src_b, imm_src, result_src,
                  reg_write, dmem_req, dmem_we, pc_en, pc_src, trap};
        act_wd = {w_imem_req, w_ir_en, w_alu_ctrl, w_alu_src_b, w_imm_src, w_result_src,
                  w_reg_write, w_dmem_req, w_dmem_we, w_pc_en, w_pc_src, w_trap};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cur_valid) begin
            vectors++;
            if (act !== cur) begin
                miscompares++;
                $display("FAIL main t=%0t instr=%h act=%h exp=%h", $time, instr, act, cur);
            end
            vectors++;
            if (act_wd !== cur_wd) begin
                miscompares++;
                $display("FAIL wdog t=%0t instr=%h act=%h exp=%h", $time, instr, act_wd, cur_wd);
            end
        end
    end

    task automatic pin(input string name, input int a, input int b);
        vectors++;
        if (a !== b) begin
            miscompares++;
            $display("FAIL %s act=%0d exp=%0d", name, a, b);
        end
    endtask

    task automatic push(input outs_t e, input logic ir, input logic dr, input logic eq,
                        input logic [31:0] ins);
        q.push_back('{e, e, ir, dr, eq, ins});
    endtask

    // Expected cycle sequence of one instruction, from FETCH to its last cycle.
    task automatic build(input logic [31:0] ins, input int fst, input int mst, input logic eq);
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        int         kind = -1;   // 0 R, 1 I, 2 lw, 3 sw, 4 branch, 5 jal
        logic [1:0] aop = SUM_OP;
        outs_t      e;
        case (op)
            7'h33: begin
                if (f3 == 3'd0 && f7 == 7'h00)      begin kind = 0; aop = SUM_OP; end
                else if (f3 == 3'd0 && f7 == 7'h20) begin kind = 0; aop = SUB_OP; end
                else if (f3 == 3'd7 && f7 == 7'h00) begin kind = 0; aop = AND_OP; end
                else if (f3 == 3'd2 && f7 == 7'h00) begin kind = 0; aop = SLT_OP; end
            end
            7'h13: begin
                if (f3 == 3'd0)      begin kind = 1; aop = SUM_OP; end
                else if (f3 == 3'd7) begin kind = 1; aop = AND_OP; end
                else if (f3 == 3'd2) begin kind = 1; aop = SLT_OP; end
            end
            7'h03: if (f3 == 3'd2) kind = 2;
            7'h23: if (f3 == 3'd2) kind = 3;
            7'h63: if (f3 == 3'd0 || f3 == 3'd1) begin kind = 4; aop = SUB_OP; end
            7'h6F: kind = 5;
            default: kind = -1;
        endcase
        e = '0; e.imem_req = 1'b1;
        for (int i = 0; i < fst; i++) push(e, 1'b0, 1'b1, eq, ins);
        e.ir_en = 1'b1;
        push(e, 1'b1, 1'b1, eq, ins);
        e = '0;
        push(e, 1'b1, 1'b1, eq, ins);
        if (kind < 0) begin
            e.trap = 1'b1;
            for (int i = 0; i < 20; i++) push(e, 1'b1, 1'b1, eq, ins);
            return;
        end
        e.alu_ctrl = aop;
        case (kind)
            1: e.alu_src_b = 1'b1;
            2: e.alu_src_b = 1'b1;
            3: begin e.alu_src_b = 1'b1; e.imm_src = IMM_S; end
            4: begin
                e.imm_src = IMM_B; e.pc_en = 1'b1;
                e.pc_src = (f3 == 3'd1) ? !eq : eq;
            end
            5: begin
                e.imm_src = IMM_J; e.pc_en = 1'b1; e.pc_src = 1'b1;
                e.reg_write = 1'b1; e.result_src = RES_PC4;
            end
            default: ;
        endcase
        push(e, 1'b1, 1'b1, eq, ins);
        if (kind == 2 || kind == 3) begin
            e = '0; e.dmem_req = 1'b1; e.dmem_we = (kind == 3);
            for (int i = 0; i < mst; i++) push(e, 1'b1, 1'b0, eq, ins);
            e.pc_en = (kind == 3);
            push(e, 1'b1, 1'b1, eq, ins);
        end
        if (kind <= 2) begin
            e = '0; e.reg_write = 1'b1; e.pc_en = 1'b1;
            e.result_src = (kind == 2) ? RES_MEM : RES_ALU;
            push(e, 1'b1, 1'b1, eq, ins);
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk); #1;
        instr = v.ins; imem_ready = v.ir; dmem_ready = v.dr; alu_eq = v.eq;
        cur = v.e; cur_wd = v.ew; cur_valid = 1'b1;
    endtask

    task automatic play();
        while (q.size() > 0) step(q.pop_front());
    endtask

    // Releases reset just after an edge; the following cycle is IDLE.
    task automatic release_idle();
        @(posedge clk); #1;
        rst_n = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        cur = '0; cur_wd = '0; cur_valid = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        cur_valid = 1'b0;
        rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        #2;
        pin("reset_outputs", int'(act), 0);
        pin("reset_outputs_wd", int'(act_wd), 0);
        release_idle();
    endtask

    task automatic run(input logic [31:0] ins, input int fst, input int mst, input logic eq);
        build(ins, fst, mst, eq);
        play();
    endtask

    initial begin
        int n;
        outs_t e;
        vectors = 0; miscompares = 0; cur_valid = 1'b0;
        rst_n = 1'b0; instr = '0; alu_eq = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        cur = '0; cur_wd = '0;

        do_reset();
        build(32'h002081B3, 0, 0, 1'b0);       // add x3,x1,x2
        pin("add_len", q.size(), 4);
        pin("add_ir_en_c1", q[0].e.ir_en, 1);
        pin("add_exec_alu", q[2].e.alu_ctrl, SUM_OP);
        pin("add_exec_srcb", q[2].e.alu_src_b, 0);
        pin("add_wb_c4", {q[3].e.reg_write, q[3].e.pc_en}, 3);
        play();
        run(32'h402081B3, 0, 0, 1'b0);         // sub
        run(32'h0020A1B3, 0, 0, 1'b0);         // slt
        run(32'h0020F1B3, 0, 0, 1'b0);         // and
        build(32'hFFF12093, 0, 0, 1'b0);       // slti x1,x2,-1
        pin("slti_alu", q[2].e.alu_ctrl, SLT_OP);
        pin("slti_srcb", q[2].e.alu_src_b, 1);
        play();
        run(32'h00500093, 0, 0, 1'b0);         // addi
        build(32'h00F17093, 0, 0, 1'b0);       // andi
        pin("andi_alu", q[2].e.alu_ctrl, AND_OP);
        play();
        build(32'h0000A283, 0, 3, 1'b0);       // lw, 3 stall cycles
        pin("lw_len", q.size(), 8);
        n = 0;
        foreach (q[i]) n += q[i].e.dmem_req;
        pin("lw_dmem_req_cycles", n, 4);
        pin("lw_wb_src", q[7].e.result_src, RES_MEM);
        play();
        run(32'h0050A223, 0, 2, 1'b0);         // sw
        build(32'h00208063, 0, 0, 1'b1);       // beq taken
        pin("beq_len", q.size(), 3);
        pin("beq_pc_src", q[2].e.pc_src, 1);
        play();
        run(32'h00208063, 0, 0, 1'b0);         // beq not taken
        build(32'h00209063, 0, 0, 1'b1);       // bne, equal
        pin("bne_pc_src", q[2].e.pc_src, 0);
        play();
        run(32'h00209063, 0, 0, 1'b0);         // bne taken
        run(32'h008000EF, 0, 0, 1'b0);         // jal x1,8
        run(32'h002081B3, 2, 0, 1'b0);         // add with fetch stall

        build(32'h0000007F, 0, 0, 1'b0);       // illegal opcode
        pin("illegal_trap", q[2].e.trap, 1);
        play();
        do_reset();
        run(32'h4020F1B3, 0, 0, 1'b0);         // funct7 alt with AND funct3
        do_reset();
        run(32'h00008283, 0, 0, 1'b0);         // lb: unsupported funct3
        do_reset();

        // imem never ready: only the watchdog instance traps, after 4 waiting cycles.
        for (int k = 0; k < 7; k++) begin
            e = '0; e.imem_req = 1'b1;
            q.push_back('{e, (k < 4) ? e : outs_t'(15'h0001), 1'b0, 1'b1, 1'b0, 32'h002081B3});
        end
        play();
        do_reset();

        // Reset asserted during MEM of sw.
        build(32'h0050A223, 0, 5, 1'b0);
        for (int i = 0; i < 5; i++) step(q.pop_front());
        q.delete();
        @(posedge clk); #1;
        cur_valid = 1'b0; dmem_ready = 1'b0;
        #1 pin("abort_pre_dmem_req", dmem_req, 1);
        rst_n = 1'b0;
        #1 pin("abort_dmem_req", dmem_req, 0);
        pin("abort_pc_en", pc_en, 0);
        release_idle();
        run(32'h002081B3, 1, 0, 1'b0);

        @(negedge clk); #1;
        cur_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
